// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage with ALU-control decode, ALU with zero/branch flag, and an independent adder
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       aluop,
  input  logic [3:0]       sel,
  input  logic             bgez_or_bltz,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [3:0]       gout,
  output logic [WIDTH-1:0] alu_result,
  output logic             zout,
  output logic [WIDTH-1:0] add_sum
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_PASS = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BGEZ = 4'b1000;
  localparam logic [3:0] OP_BLTZ = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  logic [3:0]       r_op, i_op, op;
  logic [WIDTH-1:0] res;
  logic             z, lt;
  always_comb begin
    r_op = sel == 4'b0010 ? OP_SUB :
           sel == 4'b0100 ? OP_AND :
           sel == 4'b0101 ? OP_OR  :
           sel == 4'b0111 ? OP_NOR :
           sel == 4'b1010 ? OP_SLT : OP_ADD;
    i_op = sel == 4'b1100 ? OP_AND  :
           sel == 4'b1101 ? OP_OR   :
           sel == 4'b1010 ? OP_SLT  :
           sel == 4'b0011 ? OP_PASS :
           sel == 4'b0001 ? (bgez_or_bltz ? OP_BGEZ : OP_BLTZ) : OP_ADD;
    op = aluop == 2'b00 ? OP_ADD :
         aluop == 2'b01 ? OP_SUB :
         aluop == 2'b10 ? r_op : i_op;
    lt = $signed(alu_a) < $signed(alu_b);
    res = op == OP_AND ? alu_a & alu_b :
          op == OP_OR  ? alu_a | alu_b :
          op == OP_ADD ? alu_a + alu_b :
          op == OP_SUB ? alu_a - alu_b :
          op == OP_SLT ? {{(WIDTH-1){1'b0}}, lt} :
          op == OP_NOR ? ~(alu_a | alu_b) : alu_a;
    z = op == OP_BGEZ ? ~alu_a[WIDTH-1] :
        op == OP_BLTZ ? alu_a[WIDTH-1] : res == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      gout       <= '0;
      alu_result <= '0;
      zout       <= 1'b0;
      add_sum    <= '0;
    end else if (en) begin
      gout       <= op;
      alu_result <= res;
      zout       <= z;
      add_sum    <= add_a + add_b;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit with directed vectors and a randomized reference-model phase
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst, en, bgez_or_bltz;
  logic [1:0]  aluop;
  logic [3:0]  sel;
  logic [31:0] alu_a, alu_b, add_a, add_b;
  logic [3:0]  gout;
  logic [31:0] alu_result, add_sum;
  logic        zout;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .aluop(aluop), .sel(sel),
    .bgez_or_bltz(bgez_or_bltz), .alu_a(alu_a), .alu_b(alu_b),
    .add_a(add_a), .add_b(add_b), .gout(gout), .alu_result(alu_result),
    .zout(zout), .add_sum(add_sum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [31:0] r;
    logic        z;
    logic [31:0] s;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_one(input string tag);
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    check({tag, ".gout"}, {28'd0, gout}, {28'd0, e.g});
    check({tag, ".result"}, alu_result, e.r);
    check({tag, ".zout"}, {31'd0, zout}, {31'd0, e.z});
    check({tag, ".sum"}, add_sum, e.s);
  endtask

  string prev_tag = "";

  task automatic send(input string tag, input bit r, input bit e, input logic [1:0] op,
                      input logic [3:0] s, input bit bb, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] aa, input logic [31:0] ab,
                      input logic [3:0] eg, input logic [31:0] er, input bit ez);
    exp_t x;
    @(negedge clk);
    compare_one(prev_tag);
    rst = r; en = e; aluop = op; sel = s; bgez_or_bltz = bb;
    alu_a = a; alu_b = b; add_a = aa; add_b = ab;
    if (r) x = '0;
    else if (!e) x = last;
    else x = '{g: eg, r: er, z: ez, s: aa + ab};
    q.push_back(x);
    last = x;
    prev_tag = tag;
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [3:0] s, input bit bb,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] aa, input logic [31:0] ab);
    exp_t x;
    logic [3:0] g;
    g = 4'b0010;
    if (op == 2'b01) g = 4'b0110;
    else if (op == 2'b10) begin
      if (s == 4'b0010) g = 4'b0110;
      if (s == 4'b0100) g = 4'b0000;
      if (s == 4'b0101) g = 4'b0001;
      if (s == 4'b0111) g = 4'b1100;
      if (s == 4'b1010) g = 4'b0111;
    end else if (op == 2'b11) begin
      if (s == 4'b1100) g = 4'b0000;
      if (s == 4'b1101) g = 4'b0001;
      if (s == 4'b1010) g = 4'b0111;
      if (s == 4'b0011) g = 4'b0011;
      if (s == 4'b0001) g = bb ? 4'b1000 : 4'b1001;
    end
    x.g = g;
    x.r = a;
    if (g == 4'b0000) x.r = a & b;
    if (g == 4'b0001) x.r = a | b;
    if (g == 4'b0010) x.r = a + b;
    if (g == 4'b0110) x.r = a + ~b + 32'd1;
    if (g == 4'b1100) x.r = ~a & ~b;
    if (g == 4'b0111) x.r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
    x.z = (g == 4'b1000) ? !a[31] : (g == 4'b1001) ? a[31] : (x.r == 32'd0);
    x.s = aa + ab;
    return x;
  endfunction

  initial begin
    exp_t m;
    logic [1:0]  rop;
    logic [3:0]  rs;
    logic [31:0] ra, rb, raa, rab;
    bit rbb, rr, re;
    rst = 1'b1; en = 1'b0; aluop = 2'b00; sel = 4'd0; bgez_or_bltz = 1'b0;
    alu_a = '0; alu_b = '0; add_a = '0; add_b = '0;
    last = '0;
    send("rst0", 1, 1, 2'b10, 4'b0000, 0, 32'h55, 32'h66, 32'h7, 32'h9, 0, 0, 0);
    send("rst1", 1, 1, 2'b11, 4'b1101, 1, 32'hAA, 32'h11, 32'h3, 32'h1, 0, 0, 0);
    send("hold0", 0, 0, 2'b10, 4'b0000, 0, 32'h5, 32'h6, 32'h7, 32'h8, 0, 0, 0);
    send("hold1", 0, 0, 2'b01, 4'b0000, 0, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0);
    send("r_add", 0, 1, 2'b10, 4'b0000, 0, 32'hF, 32'h3, 32'h0, 32'h0, 4'b0010, 32'h12, 0);
    send("r_sub", 0, 1, 2'b10, 4'b0010, 0, 32'hF, 32'h3, 32'h0, 32'h0, 4'b0110, 32'h0C, 0);
    send("r_and", 0, 1, 2'b10, 4'b0100, 0, 32'hF, 32'h3, 32'h0, 32'h0, 4'b0000, 32'h03, 0);
    send("r_or",  0, 1, 2'b10, 4'b0101, 0, 32'hF, 32'h3, 32'h0, 32'h0, 4'b0001, 32'h0F, 0);
    send("r_nor", 0, 1, 2'b10, 4'b0111, 0, 32'hF, 32'h3, 32'h0, 32'h0, 4'b1100, 32'hFFFFFFF0, 0);
    send("slt_neg", 0, 1, 2'b10, 4'b1010, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0111, 32'h1, 0);
    send("slt_pos", 0, 1, 2'b10, 4'b1010, 0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'b0111, 32'h0, 1);
    send("add_wrap", 0, 1, 2'b10, 4'b0000, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0010, 32'h0, 1);
    send("jr", 0, 1, 2'b10, 4'b1000, 0, 32'h40, 32'h4, 32'h0, 32'h0, 4'b0010, 32'h44, 0);
    send("r_other", 0, 1, 2'b10, 4'b1111, 0, 32'h40, 32'h4, 32'h0, 32'h0, 4'b0010, 32'h44, 0);
    send("lw_add", 0, 1, 2'b00, 4'b0101, 0, 32'h100, 32'h8, 32'h0, 32'h0, 4'b0010, 32'h108, 0);
    send("beq", 0, 1, 2'b01, 4'b0000, 0, 32'h1234, 32'h1234, 32'h0, 32'h0, 4'b0110, 32'h0, 1);
    send("bgez0", 0, 1, 2'b11, 4'b0001, 1, 32'h0, 32'h5, 32'h0, 32'h0, 4'b1000, 32'h0, 1);
    send("bgez_neg", 0, 1, 2'b11, 4'b0001, 1, 32'h80000000, 32'h5, 32'h0, 32'h0, 4'b1000, 32'h80000000, 0);
    send("bltz_neg", 0, 1, 2'b11, 4'b0001, 0, 32'h80000000, 32'h0, 32'h0, 32'h0, 4'b1001, 32'h80000000, 1);
    send("bltz_pos", 0, 1, 2'b11, 4'b0001, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b1001, 32'h0, 0);
    send("ori", 0, 1, 2'b11, 4'b1101, 0, 32'hF0, 32'h0F, 32'h0, 32'h0, 4'b0001, 32'hFF, 0);
    send("andi", 0, 1, 2'b11, 4'b1100, 0, 32'hF0, 32'h3C, 32'h0, 32'h0, 4'b0000, 32'h30, 0);
    send("slti", 0, 1, 2'b11, 4'b1010, 0, 32'h80000000, 32'h0, 32'h0, 32'h0, 4'b0111, 32'h1, 0);
    send("addi", 0, 1, 2'b11, 4'b1000, 0, 32'h10, 32'hFFFFFFF0, 32'h0, 32'h0, 4'b0010, 32'h0, 1);
    send("jal", 0, 1, 2'b11, 4'b0011, 0, 32'h1C, 32'h99, 32'h0, 32'h0, 4'b0011, 32'h1C, 0);
    send("i_other", 0, 1, 2'b11, 4'b0110, 0, 32'h2, 32'h3, 32'h0, 32'h0, 4'b0010, 32'h5, 0);
    send("adder", 0, 1, 2'b10, 4'b0000, 0, 32'h1, 32'h2, 32'h8, 32'h4, 4'b0010, 32'h3, 0);
    send("adder_wrap", 0, 1, 2'b01, 4'b0000, 0, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 4'b0110, 32'h0, 1);
    send("en_hold0", 0, 0, 2'b10, 4'b0111, 0, 32'hDEAD, 32'hBEEF, 32'h100, 32'h200, 0, 0, 0);
    send("en_hold1", 0, 0, 2'b11, 4'b0001, 1, 32'h80000000, 32'h1, 32'h5, 32'h6, 0, 0, 0);
    send("load", 0, 1, 2'b10, 4'b0101, 0, 32'hA0, 32'h0A, 32'h20, 32'h4, 4'b0001, 32'hAA, 0);
    send("rst_en", 1, 1, 2'b10, 4'b0101, 0, 32'hA0, 32'h0A, 32'h20, 32'h4, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      rs  = 4'($urandom_range(0, 15));
      rbb = 1'($urandom_range(0, 1));
      ra  = $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 3));
      raa = $urandom();
      rab = $urandom();
      rr  = ($urandom_range(0, 15) == 0);
      re  = ($urandom_range(0, 4) != 0);
      m = model(rop, rs, rbb, ra, rb, raa, rab);
      send("rand", rr, re, rop, rs, rbb, ra, rb, raa, rab, m.g, m.r, m.z);
    end
    @(negedge clk);
    compare_one(prev_tag);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
